// File: rtl/clk_ctrl_pkg.sv
// Shared opcodes and state encoding for the clock-step sequencer and its command decoder.
package clk_ctrl_pkg;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_SET_DIV = 3'd1;
    localparam logic [2:0] OP_STEP    = 3'd2;
    localparam logic [2:0] OP_RUN     = 3'd3;
    localparam logic [2:0] OP_STOP    = 3'd4;
    localparam logic [2:0] OP_CLR_CNT = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_PULSING  = 3'd2,
        ST_RUNNING  = 3'd3,
        ST_STOPPING = 3'd4
    } state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/clk_step_controller.sv
// Command-driven sequencer for the clock divider: N-cycle step bursts, free-run,
// stop on command or processor halt, with a saturating delivered-cycle count.
module clk_step_controller
    import clk_ctrl_pkg::*;
#(
    parameter int COUNTER_BITS       = 32,
    parameter int PULSE_CONTROL_BITS = 32,
    parameter int DEFAULT_DIV        = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic [31:0]                   cmd_arg,
    input  logic                          halt_req,
    output logic                          div_write_pulse,
    output logic [PULSE_CONTROL_BITS-1:0] div_pulse,
    output logic                          div_option,
    output logic                          div_out_enable,
    output logic [COUNTER_BITS-1:0]       div_divider,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [31:0]                   cycles_run
);

    state_e                        state_q;
    logic [PULSE_CONTROL_BITS-1:0] shadow_q;
    logic [PULSE_CONTROL_BITS-1:0] pulse_q;
    logic [COUNTER_BITS-1:0]       divider_q;
    logic                          wr_q, opt_q, en_q, busy_q, done_q, err_q, ready_q;
    logic [31:0]                   cycles_q, cycles_d;
    logic                          fire, stop_req;
    logic [PULSE_CONTROL_BITS-1:0] step_arg;

    assign fire     = cmd_valid && ready_q;
    assign stop_req = halt_req || (fire && cmd_op == OP_STOP);
    assign step_arg = cmd_arg[PULSE_CONTROL_BITS-1:0];
    assign cycles_d = sat_inc(cycles_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shadow_q  <= '0;
            pulse_q   <= '0;
            divider_q <= COUNTER_BITS'(DEFAULT_DIV);
            wr_q      <= 1'b0;
            opt_q     <= 1'b0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
            cycles_q  <= '0;
        end else begin
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fire) begin
                        case (cmd_op)
                            OP_NOP: ;
                            OP_SET_DIV: divider_q <= cmd_arg[COUNTER_BITS-1:0];
                            OP_STEP: begin
                                if (step_arg == '0) begin
                                    done_q <= 1'b1;
                                end else begin
                                    state_q  <= ST_LOAD;
                                    wr_q     <= 1'b1;
                                    pulse_q  <= step_arg;
                                    opt_q    <= 1'b0;
                                    shadow_q <= step_arg;
                                    busy_q   <= 1'b1;
                                    ready_q  <= 1'b0;
                                end
                            end
                            OP_RUN: begin
                                state_q <= ST_RUNNING;
                                opt_q   <= 1'b1;
                                en_q    <= 1'b1;
                                busy_q  <= 1'b1;
                            end
                            OP_STOP:    done_q   <= 1'b1;
                            OP_CLR_CNT: cycles_q <= '0;
                            default:    err_q    <= 1'b1;
                        endcase
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_PULSING;
                    en_q    <= 1'b1;
                    ready_q <= 1'b1;
                end
                ST_PULSING: begin
                    if (shadow_q != '0)
                        cycles_q <= cycles_d;
                    // Zero the divider's pulse count: a leftover count would keep gating the clock.
                    if (stop_req) begin
                        state_q <= ST_STOPPING;
                        wr_q    <= 1'b1;
                        pulse_q <= '0;
                        en_q    <= 1'b0;
                        ready_q <= 1'b0;
                    end else begin
                        shadow_q <= shadow_q - 1'b1;
                        if (shadow_q == PULSE_CONTROL_BITS'(1)) begin
                            state_q <= ST_IDLE;
                            en_q    <= 1'b0;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (fire && cmd_op != OP_NOP) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_RUNNING: begin
                    cycles_q <= cycles_d;
                    // A command colliding with the stop is dropped so done and err stay exclusive.
                    if (stop_req) begin
                        state_q <= ST_IDLE;
                        en_q    <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (fire && cmd_op != OP_NOP) begin
                        err_q <= 1'b1;
                    end
                end
                ST_STOPPING: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready       = ready_q;
    assign div_write_pulse = wr_q;
    assign div_pulse       = pulse_q;
    assign div_option      = opt_q;
    assign div_out_enable  = en_q;
    assign div_divider     = divider_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign cycles_run      = cycles_q;

endmodule
